gumnut_dmem_ws: RTL and testbench
=================================

GUMNUT_DMEM_WS -- requirements
Module: gumnut_dmem_ws

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_W, default 8: data word width.
- ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
- WAIT_CYCLES, default 1: wait states per access, legal range 0..15.

REQ-002 The block SHALL have the following ports, with the clock and reset listed first:
- clk_i  input  1  system clock.
- rst_i  input  1  reset.
- cyc_i  input  1  bus cycle valid.
- stb_i  input  1  strobe.
- we_i  input  1  1 = write, 0 = read.
- adr_i  input  ADDR_W  word address.
- dat_i  input  DATA_W  write data.
- par_inj_i  input  1  parity-error injection for writes.
- dat_o  output  DATA_W  read data.
- ack_o  output  1  access complete.
- busy_o  output  1  access in progress.
- err_o  output  1  read parity error, qualified by ack_o.

REQ-003 There SHALL be one clock, clk_i; reset is synchronous and active-high on rst_i, and all state changes only on the rising edge of clk_i.

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT and ACK.

REQ-005 In IDLE, a request is cyc_i=1 and stb_i=1 at a rising edge. On a request the block SHALL:
- latch adr_i, dat_i, we_i and par_inj_i;
- load the wait counter with WAIT_CYCLES;
- go to WAIT if WAIT_CYCLES>0, else go to ACK.

REQ-006 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to ACK on the edge where the counter equals 1.

REQ-007 ack_o SHALL be high for exactly one cycle, in state ACK, and SHALL first be high WAIT_CYCLES+1 cycles after the edge that sampled the request.

REQ-008 ACK SHALL always go to IDLE. stb_i is ignored during ACK, so the sustained rate is one access per WAIT_CYCLES+2 cycles.

REQ-009 A write SHALL update memory at the latched address with the latched data on the edge entering ACK. dat_o is unchanged by writes.

REQ-010 A read SHALL load dat_o with the memory word at the latched address on the edge entering ACK. dat_o then holds that value until the next read completes.

REQ-011 Abort: if cyc_i=0 or stb_i=0 at any edge while in WAIT, the block SHALL:
- go to IDLE;
- perform no write;
- not assert ack_o;
- leave dat_o unchanged.

REQ-012 Changes on adr_i, dat_i, we_i and par_inj_i after the request edge SHALL be ignored until the FSM is next in IDLE.

REQ-013 busy_o SHALL be 1 in WAIT and ACK, and 0 in IDLE.

REQ-014 Every address SHALL be valid; there is no wrap-around or out-of-range case.

Reset
REQ-015 While rst_i=1 at an edge, the block SHALL set FSM=IDLE, counter=0, ack_o=0, busy_o=0, err_o=0 and dat_o=0.

REQ-016 Reset mid-access SHALL discard a pending write, so memory is unmodified, and no ack_o SHALL be issued for that access.

REQ-017 Reset SHALL NOT clear memory contents. Contents are undefined until written.

Configuration
REQ-018 The parity feature SHALL be controlled by the macro GUMNUT_DMEM_PARITY_EN.

REQ-019 With GUMNUT_DMEM_PARITY_EN defined:
- each word stores one extra even-parity bit, computed over the latched write data and XORed with the latched par_inj_i;
- on a read ack, err_o SHALL be 1 if the stored parity does not match the parity recomputed over the read word, else 0;
- err_o SHALL be 0 whenever ack_o=0 and on write acks.

REQ-020 Without GUMNUT_DMEM_PARITY_EN:
- no parity storage is built;
- err_o SHALL be tied to 0;
- par_inj_i SHALL be ignored.

REQ-021 All ports SHALL exist in both configurations.

Verification
REQ-022 WAIT_CYCLES=2: write 0xA5 to address 0x10, request sampled at edge 0 -> ack_o high in cycle 3 only, busy_o high in cycles 1-3. A subsequent read of 0x10 -> dat_o=0xA5 with ack_o, err_o=0.

REQ-023 WAIT_CYCLES=0: write 0x3C to 0x00, then read 0x00 with stb_i held high -> each ack 1 cycle after its request, one IDLE cycle between accesses, read returns 0x3C.

REQ-024 WAIT_CYCLES=3: write 0xFF to 0x20, then drop stb_i in the second WAIT cycle -> no ack_o, FSM returns to IDLE. A later read of 0x20 returns the prior value (0x11, preloaded), not 0xFF.

REQ-025 WAIT_CYCLES=2: write 0x77 to 0x05, then assert rst_i in the first WAIT cycle -> ack_o, busy_o and dat_o are 0 the next cycle. A read of 0x05 returns the preloaded 0x00.

REQ-026 With GUMNUT_DMEM_PARITY_EN: write 0x01 to 0x40 with par_inj_i=1, then read 0x40 -> dat_o=0x01, err_o=1 with ack_o. Rewrite 0x40 with par_inj_i=0 and read -> err_o=0. Without the macro, the same sequence -> err_o=0 throughout.

REQ-027 A bench check SHALL run over all 2**ADDR_W addresses (ADDR_W=8): write address XOR 0x5A to each, then read each back -> all match; ack latency is constant at WAIT_CYCLES+1.

Source files
------------

// File: rtl/gumnut_dmem_ws.sv
// -----------------------------------------------------------------------------
// gumnut_dmem_ws -- single-port data memory with a Wishbone-style handshake and
// a programmable number of wait states per access.
//
// One access takes WAIT_CYCLES+2 cycles: IDLE (request sampled), WAIT_CYCLES
// cycles in WAIT, and a single ACK cycle. Dropping cyc_i or stb_i while in
// WAIT aborts the access: nothing is written, no ack_o is issued and dat_o is
// left unchanged. Memory contents are not touched by reset.
//
// Optional feature (macro GUMNUT_DMEM_PARITY_EN): each word stores an extra
// even-parity bit (optionally corrupted via par_inj_i). err_o reports a
// mismatch on read acks. Without the macro, err_o is tied low and par_inj_i is
// ignored.
//
// Parameters:
//   DATA_W      data word width
//   ADDR_W      address width, DEPTH = 2**ADDR_W words
//   WAIT_CYCLES wait states per access, 0..15
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   cyc_i      bus cycle valid
//   stb_i      strobe
//   we_i       1 = write, 0 = read
//   adr_i      word address
//   dat_i      write data
//   par_inj_i  parity-error injection for writes
//   dat_o      read data, held until the next read completes
//   ack_o      one-cycle access complete
//   busy_o     access in progress (WAIT or ACK)
//   err_o      read parity error, qualified by ack_o
// -----------------------------------------------------------------------------
module gumnut_dmem_ws #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              par_inj_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              ack_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int         DEPTH     = 2 ** ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // Even-parity bit over a data word.
   function automatic logic even_par(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   wdat_q;
   logic                we_q;
   logic [DATA_W-1:0]   dat_q;
   logic                ack_q;
   logic                busy_q;
   logic                err_q;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                req_s;
   logic                enter_ack_s;
   logic                acc_we_s;
   logic [ADDR_W-1:0]   acc_adr_s;
   logic [DATA_W-1:0]   acc_dat_s;
   logic [DATA_W-1:0]   rd_word_s;
   logic                rd_err_s;
   logic                wr_en_s;

   // Next-state decode: request, wait countdown, abort and completion.
   always_comb begin
      req_s       = cyc_i & stb_i;
      state_d     = state_q;
      cnt_d       = cnt_q;
      enter_ack_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               cnt_d = WAIT_INIT;
               if (WAIT_INIT == 4'd0) begin
                  state_d     = ST_ACK;
                  enter_ack_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Abort takes priority over completion, even on the final wait edge.
            if (!req_s) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d     = ST_ACK;
                  enter_ack_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Effective access fields: with zero wait states the access completes on the
   // request edge itself, so the live inputs stand in for the latched copies.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_we_s  = we_i;
         acc_adr_s = adr_i;
         acc_dat_s = dat_i;
      end else begin
         acc_we_s  = we_q;
         acc_adr_s = adr_q;
         acc_dat_s = wdat_q;
      end
   end

   assign rd_word_s = mem_q[acc_adr_s];
   assign wr_en_s   = enter_ack_s & acc_we_s & ~rst_i;

   // Data array write port; deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[acc_adr_s] <= acc_dat_s;
      end
   end

`ifdef GUMNUT_DMEM_PARITY_EN
   logic par_q [DEPTH];
   logic inj_q;
   logic acc_inj_s;

   // Injection flag follows the same live/latched selection as the other fields.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_inj_s = par_inj_i;
      end else begin
         acc_inj_s = inj_q;
      end
   end

   // Latch the injection request alongside the rest of the access.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inj_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && req_s) begin
         inj_q <= par_inj_i;
      end
   end

   // Parity array write port, written together with the data word.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         par_q[acc_adr_s] <= even_par(acc_dat_s) ^ acc_inj_s;
      end
   end

   assign rd_err_s = par_q[acc_adr_s] ^ even_par(rd_word_s);
`else
   logic unused_par_inj_s;
   assign unused_par_inj_s = par_inj_i;
   assign rd_err_s         = 1'b0;
`endif

   // FSM state, request latches and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= '0;
         wdat_q  <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == ST_IDLE) && req_s) begin
            adr_q  <= adr_i;
            wdat_q <= dat_i;
            we_q   <= we_i;
         end
         if (enter_ack_s && !acc_we_s) begin
            dat_q <= rd_word_s;
         end
         ack_q  <= (state_d == ST_ACK);
         busy_q <= (state_d != ST_IDLE);
         err_q  <= enter_ack_s & ~acc_we_s & rd_err_s;
      end
   end

   assign dat_o  = dat_q;
   assign ack_o  = ack_q;
   assign busy_o = busy_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_gumnut_dmem_ws.sv
// Self-checking bench for gumnut_dmem_ws (DATA_W=8, ADDR_W=8, WAIT_CYCLES=2).
// Expected values come from a word-level memory model (array of stored words
// plus a per-word "written with injection" flag) and from hand-computed tables.
module tb_gumnut_dmem_ws;

   localparam int WC = 2;
`ifdef GUMNUT_DMEM_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i, cyc_i, stb_i, we_i, par_inj_i;
   logic [7:0] adr_i, dat_i, dat_o;
   logic       ack_o, busy_o, err_o;

   int         checks   = 0;
   int         failures = 0;

   logic [7:0] mem_m [256];
   logic       inj_m [256];
   logic [7:0] last_rd;

   typedef struct {
      logic       we;
      logic [7:0] adr;
      logic [7:0] dat;
      logic       inj;
      logic [7:0] exp_dat;
      logic       exp_err;
   } vec_t;

   vec_t tbl [10];

   gumnut_dmem_ws #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(WC)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cyc_i     (cyc_i),
      .stb_i     (stb_i),
      .we_i      (we_i),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .par_inj_i (par_inj_i),
      .dat_o     (dat_o),
      .ack_o     (ack_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One complete access with stb held until ack; inputs are scrambled after
   // the request edge to show they are ignored.
   task automatic bus(input string nm, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input logic inj,
                      input logic [7:0] exp_dat, input logic exp_err);
      int   lat;
      logic busy_ok;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d; par_inj_i = inj;
      tick;
      adr_i = 8'($urandom); dat_i = 8'($urandom);
      we_i = 1'($urandom); par_inj_i = 1'($urandom);
      lat = 1;
      busy_ok = 1'b1;
      while (ack_o !== 1'b1 && lat < 40) begin
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         tick;
         lat++;
      end
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      cyc_i = 1'b0; stb_i = 1'b0;
      chk({nm, " latency"}, 32'(lat), 32'(WC + 1));
      chk({nm, " busy"}, 32'(busy_ok), 32'd1);
      chk({nm, " dat_o"}, 32'(dat_o), 32'(exp_dat));
      chk({nm, " err_o"}, 32'(err_o), 32'(exp_err));
      tick;
      chk({nm, " after_ack"}, 32'({ack_o, busy_o, err_o}), 32'd0);
   endtask

   task automatic mwrite(input string nm, input logic [7:0] a, input logic [7:0] d, input logic inj);
      bus(nm, 1'b1, a, d, inj, last_rd, 1'b0);
      mem_m[a] = d;
      inj_m[a] = inj;
   endtask

   task automatic mread(input string nm, input logic [7:0] a);
      bus(nm, 1'b0, a, 8'h00, 1'b0, mem_m[a], PAR & inj_m[a]);
      last_rd = mem_m[a];
   endtask

   initial begin
      logic exp_ack, exp_busy;

      tbl[0] = '{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[2] = '{1'b1, 8'h00, 8'h3C, 1'b0, 8'hA5, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0};
      tbl[4] = '{1'b1, 8'h40, 8'h01, 1'b1, 8'h3C, 1'b0};
      tbl[5] = '{1'b0, 8'h40, 8'h00, 1'b0, 8'h01, PAR};
      tbl[6] = '{1'b1, 8'h40, 8'h01, 1'b0, 8'h01, 1'b0};
      tbl[7] = '{1'b0, 8'h40, 8'h00, 1'b0, 8'h01, 1'b0};
      tbl[8] = '{1'b1, 8'hFF, 8'h80, 1'b0, 8'h01, 1'b0};
      tbl[9] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h80, 1'b0};

      rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      adr_i = 8'h00; dat_i = 8'h00; par_inj_i = 1'b0;
      tick;
      tick;
      chk("reset outputs", 32'({ack_o, busy_o, err_o}), 32'd0);
      chk("reset dat_o", 32'(dat_o), 32'd0);
      rst_i = 1'b0;
      last_rd = 8'h00;
      tick;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         bus($sformatf("tbl%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat,
             tbl[i].inj, tbl[i].exp_dat, tbl[i].exp_err);
         if (!tbl[i].we) last_rd = tbl[i].exp_dat;
      end

      // Back-to-back: write then read with stb held high the whole time.
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h00; dat_i = 8'h3C; par_inj_i = 1'b0;
      tick;
      we_i = 1'b0; dat_i = 8'hEE;
      for (int t = 1; t <= 2 * WC + 3; t++) begin
         exp_ack  = (t == WC + 1) || (t == 2 * WC + 3);
         exp_busy = (t != WC + 2);
         chk($sformatf("b2b ack t%0d", t), 32'(ack_o), 32'(exp_ack));
         chk($sformatf("b2b busy t%0d", t), 32'(busy_o), 32'(exp_busy));
         if (t < 2 * WC + 3) tick;
      end
      chk("b2b dat_o", 32'(dat_o), 32'h3C);
      cyc_i = 1'b0; stb_i = 1'b0;
      tick;
      mem_m[0] = 8'h3C; inj_m[0] = 1'b0; last_rd = 8'h3C;

      // Abort: strobe dropped in the second wait cycle.
      mwrite("abort_pre", 8'h20, 8'h11, 1'b0);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h20; dat_i = 8'hFF;
      tick;
      tick;
      stb_i = 1'b0;
      tick;
      chk("abort ack/busy", 32'({ack_o, busy_o}), 32'd0);
      cyc_i = 1'b0;
      tick;
      chk("abort idle", 32'({ack_o, busy_o}), 32'd0);
      chk("abort dat_o", 32'(dat_o), 32'(last_rd));
      mread("abort_rd", 8'h20);

      // Reset in the first wait cycle of a write.
      mwrite("rst_pre", 8'h05, 8'h00, 1'b0);
      mread("rst_pre_rd", 8'h20);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h05; dat_i = 8'h77;
      tick;
      rst_i = 1'b1;
      tick;
      chk("midrst outputs", 32'({ack_o, busy_o, err_o}), 32'd0);
      chk("midrst dat_o", 32'(dat_o), 32'd0);
      rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
      last_rd = 8'h00;
      tick;
      mread("midrst_rd", 8'h05);

      // Full address sweep.
      for (int a = 0; a < 256; a++) mwrite("sweep_wr", 8'(a), 8'(a) ^ 8'h5A, 1'b0);
      for (int a = 0; a < 256; a++) mread("sweep_rd", 8'(a));

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(1, 0) == 1)
            mwrite("rand_wr", 8'($urandom), 8'($urandom), 1'($urandom));
         else
            mread("rand_rd", 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
